stack_ctrl_ext: RTL
===================

Name: stack_ctrl_ext

Overview:
- Parametrised multicycle controller for the stack-machine CPU.
- Sequences fetch/decode/execute for an extended 4-bit opcode set: adds OR, DUP, SWAP and HALT to the base stack operations.
- Owns the stack-depth counter and detects underflow, overflow, illegal opcodes and memory time-outs.
- Handshakes with a variable-latency memory through mem_ready.
- Drives the existing stack/ALU/PC datapath, with operand latches A and B added.

Parameters:
- SP_W, 4: stack depth is DEPTH = 2**SP_W entries; depth counter is SP_W+1 bits wide.
- WAIT_MAX, 15: maximum number of cycles the block waits for mem_ready before a time-out trap (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- opcode  in  4  IR opcode field; stable from DECODE until the instruction's last state.
- zero  in  1  datapath flag: register A == 0.
- mem_ready  in  1  memory access completes this cycle.
- load_ir  out  1  capture memory data into IR.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request; write data is register A.
- mem_adr_sel  out  1  0 = PC, 1 = IR operand address.
- pc_sel  out  2  0 = hold, 1 = PC+1, 2 = IR operand (jump target).
- pop  out  1  pop the stack top.
- push  out  1  push onto the stack.
- push_sel  out  2  push source: 0 = ALU, 1 = memory data, 2 = reg A, 3 = reg B.
- lat_a  out  1  latch the current top into register A.
- lat_b  out  1  latch the current top into register B.
- alu_op  out  3  ALU operation: 0 = B+A, 1 = B-A, 2 = B&A, 3 = ~A, 4 = B|A.
- depth  out  SP_W+1  current stack occupancy, 0..DEPTH.
- halted  out  1  sticky; set by HALT.
- trap  out  1  sticky; set on any fault.
- trap_cause  out  3  fault code: 0 = none, 1 = underflow, 2 = overflow, 3 = illegal opcode, 4 = memory time-out.

Behaviour:
- Reset:
  - state = FETCH, depth = 0, halted = 0, trap = 0, trap_cause = 0, wait counter = 0.
  - All strobes, pc_sel, push_sel and alu_op are forced to 0 while rst is high.
- Opcode map:
  - ADD 0000, SUB 0001, AND 0010, NOT 0011, PUSH 0100, POP 0101.
  - JMP 0110, JZ 0111, DUP 1000, SWAP 1001, OR 1010, HALT 1111.
  - All other codes are illegal.
- Outputs are Moore outputs of the state, except three combinational terms:
  - load_ir and pc_sel=1 in FETCH are qualified by mem_ready.
  - pc_sel=2 in JZ_EVAL is qualified by zero.
  - push in PUSH_M is qualified by mem_ready.
- FETCH: mem_read=1, mem_adr_sel=0. On mem_ready: load_ir=1, pc_sel=1, next state DECODE. Otherwise stay in FETCH.
- DECODE: asserts no outputs. Checks are applied in priority order:
  - illegal opcode -> TRAP, cause 3;
  - depth < pops needed -> TRAP, cause 1;
  - depth + net growth > DEPTH -> TRAP, cause 2;
  - otherwise dispatch.
- Pops needed / net growth per opcode:
  - ADD, SUB, AND, OR: 2 / -1.
  - NOT: 1 / 0.
  - PUSH: 0 / +1.
  - POP: 1 / -1.
  - JZ: 1 / -1.
  - DUP: 1 / +1.
  - SWAP: 2 / 0.
  - JMP, HALT: 0 / 0.
- Execute sequences (one cycle per state unless waiting):
  - Binary ALU op: POP_A(pop, lat_a) -> POP_B(pop, lat_b) -> PUSH_R(push, push_sel=0, alu_op per opcode) -> FETCH.
  - NOT: POP_A -> PUSH_R(alu_op=3) -> FETCH.
  - PUSH: PUSH_M(mem_read, mem_adr_sel=1; on mem_ready push, push_sel=1) -> FETCH.
  - POP: POP_A -> MEM_WR(mem_write, mem_adr_sel=1) held until mem_ready -> FETCH.
  - JMP: JMP(pc_sel=2) -> FETCH.
  - JZ: POP_A -> JZ_EVAL(pc_sel=2 if zero, else 0) -> FETCH.
  - DUP: POP_A -> PUSH_A1(push, sel=2) -> PUSH_A2(push, sel=2) -> FETCH.
  - SWAP: POP_A -> POP_B -> PUSH_A(push, sel=2) -> PUSH_B(push, sel=3) -> FETCH. The old top ends up second.
  - HALT: -> HALTED; halted=1.
- HALTED and TRAP are absorbing states with all strobes at 0. Only rst leaves them.
- Depth counter:
  - +1 on every clock edge with push=1; -1 on every edge with pop=1.
  - push and pop are never asserted in the same cycle.
  - DECODE checks guarantee the counter never wraps.
- Wait counter:
  - Counts cycles spent in FETCH, PUSH_M or MEM_WR while mem_ready=0.
  - Clears on mem_ready and on every state change.
  - When it reaches WAIT_MAX with mem_ready still 0 -> TRAP, cause 4, with no memory side effect.
  - mem_ready arriving in the same cycle the count reaches WAIT_MAX is accepted; no trap.
- Async reset mid-instruction: aborts immediately. Depth returns to 0; the datapath stack contents are don't-care.

Test Plan:
- Reset, then PUSH(ready after 2 wait cycles) x2 with data 5, 3, then SUB -> stack top = 2, depth = 1. Check PUSH_M holds mem_read for 3 cycles, and the SUB sequence POP_A, POP_B, PUSH_R with alu_op = 1.
- Depth = 2 with top 7 over 9, then SWAP -> top = 9, second = 7, depth = 2. Then DUP -> depth = 3 and the top two entries are both 9.
- JZ with top = 0 -> pc_sel = 2 in JZ_EVAL and the PC loads the target. JZ with top = 4 -> pc_sel = 0. Depth decrements in both cases.
- From depth = 0, ADD -> trap = 1, cause = 1, with no pop ever asserted. Push to depth = 16 (SP_W = 4), then PUSH -> trap cause = 2. Opcode 1100 -> trap cause = 3.
- Hold mem_ready low in FETCH -> trap cause = 4 after exactly WAIT_MAX (15) waiting cycles. Raise mem_ready in that same cycle instead -> DECODE, no trap.
- HALT -> halted = 1 and all strobes stay 0 for 20 cycles. Assert rst mid-DUP -> depth = 0, state FETCH, halted = 0, trap = 0.

Source files
------------

// File: rtl/stack_ctrl_ext.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_ctrl_ext : multicycle fetch/decode/execute controller, extended ISA
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module stack_ctrl_ext #(
  parameter int SP_W     = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            load_ir,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_adr_sel,
  output logic [1:0]      pc_sel,
  output logic            pop,
  output logic            push,
  output logic [1:0]      push_sel,
  output logic            lat_a,
  output logic            lat_b,
  output logic [2:0]      alu_op,
  output logic [SP_W:0]   depth,
  output logic            halted,
  output logic            trap,
  output logic [2:0]      trap_cause
);

  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_SUB  = 4'b0001;
  localparam logic [3:0] c_OP_AND  = 4'b0010;
  localparam logic [3:0] c_OP_NOT  = 4'b0011;
  localparam logic [3:0] c_OP_PUSH = 4'b0100;
  localparam logic [3:0] c_OP_POP  = 4'b0101;
  localparam logic [3:0] c_OP_JMP  = 4'b0110;
  localparam logic [3:0] c_OP_JZ   = 4'b0111;
  localparam logic [3:0] c_OP_DUP  = 4'b1000;
  localparam logic [3:0] c_OP_SWAP = 4'b1001;
  localparam logic [3:0] c_OP_OR   = 4'b1010;
  localparam logic [3:0] c_OP_HALT = 4'b1111;

  localparam logic [SP_W:0] c_DEPTH    = {1'b1, {SP_W{1'b0}}};
  localparam logic [7:0]    c_WAIT_MAX = 8'(WAIT_MAX);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_POP_A, S_POP_B, S_PUSH_R, S_PUSH_M, S_MEM_WR, S_JMP,
    S_JZ_EVAL, S_PUSH_A1, S_PUSH_A2, S_PUSH_A, S_PUSH_B, S_HALTED, S_TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [SP_W:0] depth_q, depth_d;
  logic [7:0]    wait_q, wait_d;
  logic [2:0]    cause_q, cause_d;

  logic       w_legal, w_grow, w_waiting, w_timeout;
  logic [1:0] w_need;

  // Stack requirements of the opcode being decoded
  always_comb begin
    w_legal = 1'b1;
    w_need  = 2'd0;
    w_grow  = 1'b0;
    case (opcode)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SWAP: w_need = 2'd2;
      c_OP_NOT, c_OP_POP, c_OP_JZ:                      w_need = 2'd1;
      c_OP_DUP:  begin w_need = 2'd1; w_grow = 1'b1; end
      c_OP_PUSH: w_grow = 1'b1;
      c_OP_JMP, c_OP_HALT: ;
      default:   w_legal = 1'b0;
    endcase
  end

  assign w_timeout = !mem_ready && ((wait_q + 8'd1) == c_WAIT_MAX);

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    w_waiting   = 1'b0;
    load_ir     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_adr_sel = 1'b0;
    pc_sel      = 2'd0;
    pop         = 1'b0;
    push        = 1'b0;
    push_sel    = 2'd0;
    lat_a       = 1'b0;
    lat_b       = 1'b0;
    alu_op      = 3'd0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        w_waiting = 1'b1;
        if (mem_ready) begin
          load_ir = 1'b1;
          pc_sel  = 2'd1;
          state_d = S_DECODE;
        end else if (w_timeout) begin
          state_d = S_TRAP;
          cause_d = 3'd4;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          state_d = S_TRAP;
          cause_d = 3'd3;
        end else if (depth_q < (SP_W+1)'(w_need)) begin
          state_d = S_TRAP;
          cause_d = 3'd1;
        end else if (w_grow && (depth_q == c_DEPTH)) begin
          state_d = S_TRAP;
          cause_d = 3'd2;
        end else begin
          case (opcode)
            c_OP_PUSH: state_d = S_PUSH_M;
            c_OP_JMP:  state_d = S_JMP;
            c_OP_HALT: state_d = S_HALTED;
            default:   state_d = S_POP_A;
          endcase
        end
      end
      S_POP_A: begin
        pop   = 1'b1;
        lat_a = 1'b1;
        case (opcode)
          c_OP_NOT: state_d = S_PUSH_R;
          c_OP_POP: state_d = S_MEM_WR;
          c_OP_JZ:  state_d = S_JZ_EVAL;
          c_OP_DUP: state_d = S_PUSH_A1;
          default:  state_d = S_POP_B;
        endcase
      end
      S_POP_B: begin
        pop     = 1'b1;
        lat_b   = 1'b1;
        state_d = (opcode == c_OP_SWAP) ? S_PUSH_A : S_PUSH_R;
      end
      S_PUSH_R: begin
        push    = 1'b1;
        state_d = S_FETCH;
        case (opcode)
          c_OP_SUB: alu_op = 3'd1;
          c_OP_AND: alu_op = 3'd2;
          c_OP_NOT: alu_op = 3'd3;
          c_OP_OR:  alu_op = 3'd4;
          default:  alu_op = 3'd0;
        endcase
      end
      S_PUSH_M: begin
        mem_read    = 1'b1;
        mem_adr_sel = 1'b1;
        push_sel    = 2'd1;
        w_waiting   = 1'b1;
        if (mem_ready) begin
          push    = 1'b1;
          state_d = S_FETCH;
        end else if (w_timeout) begin
          state_d = S_TRAP;
          cause_d = 3'd4;
        end
      end
      S_MEM_WR: begin
        mem_write   = 1'b1;
        mem_adr_sel = 1'b1;
        w_waiting   = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (w_timeout) begin
          state_d = S_TRAP;
          cause_d = 3'd4;
        end
      end
      S_JMP: begin
        pc_sel  = 2'd2;
        state_d = S_FETCH;
      end
      S_JZ_EVAL: begin
        pc_sel  = zero ? 2'd2 : 2'd0;
        state_d = S_FETCH;
      end
      S_PUSH_A1: begin push = 1'b1; push_sel = 2'd2; state_d = S_PUSH_A2; end
      S_PUSH_A2: begin push = 1'b1; push_sel = 2'd2; state_d = S_FETCH;   end
      S_PUSH_A:  begin push = 1'b1; push_sel = 2'd2; state_d = S_PUSH_B;  end
      S_PUSH_B:  begin push = 1'b1; push_sel = 2'd3; state_d = S_FETCH;   end
      S_HALTED, S_TRAP: ;
      default: state_d = S_FETCH;
    endcase

    // Strobes must be quiet for the whole time reset is held
    if (rst) begin
      load_ir     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_adr_sel = 1'b0;
      pc_sel      = 2'd0;
      pop         = 1'b0;
      push        = 1'b0;
      push_sel    = 2'd0;
      lat_a       = 1'b0;
      lat_b       = 1'b0;
      alu_op      = 3'd0;
    end
  end

  always_comb begin
    depth_d = depth_q;
    if (push)     depth_d = depth_q + 1'b1;
    else if (pop) depth_d = depth_q - 1'b1;
    wait_d = (w_waiting && !mem_ready && (state_d == state_q)) ? wait_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      depth_q <= '0;
      wait_q  <= 8'd0;
      cause_q <= 3'd0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  assign depth      = depth_q;
  assign halted     = (state_q == S_HALTED);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule
`default_nettype wire
